// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types and constants for the APB4 completer memory.
//   state_t       : FSM state encoding (IDLE, ACCESS)
//   DEF_*         : default parameter values for apb_slave_mem
//   WAIT_CNT_W    : width of the wait-state counter (WAIT_STATES range 0-15)
//   strb_lsb()    : byte-offset bit count, log2(DATA_WIDTH/8)
package apb_slv_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned DEF_ADDR_WIDTH  = 8;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_MEM_DEPTH   = 32;
    localparam int unsigned DEF_WAIT_STATES = 2;
    localparam int unsigned WAIT_CNT_W      = 4;

    function automatic int unsigned strb_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB4 bus between a requester and the apb_slave_mem completer.
//   psel, penable, pwrite, paddr, pwdata, pstrb : requester -> completer
//   prdata, pready, pslverr                     : completer -> requester
//   modports: master (requester side), slave (completer side)
interface apb_slave_mem_if
    import apb_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slv_ram.sv
// apb_slv_ram: word-organised memory with byte-lane write enables and a
// registered read port. Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable; i_wstrb selects the byte lanes written
//   i_waddr : write word index
//   i_wdata : write data
//   i_wstrb : write byte lanes
//   i_re    : read enable; loads o_rdata from i_raddr on the clock edge
//   i_raddr : read word index
//   o_rdata : registered read data
module apb_slv_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [$clog2(DEPTH)-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    input  logic [DATA_WIDTH/8-1:0]       i_wstrb,
    input  logic                          i_re,
    input  logic [$clog2(DEPTH)-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0]         o_rdata
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer backed by a local word memory.
// Supports wait-state insertion, byte-strobed writes and error responses
// for misaligned, out-of-range, and strobed-read accesses.
//   pclk   : bus clock, all state on rising edge
//   preset : asynchronous active-high reset
//   bus    : apb_slave_mem_if.slave (psel/penable/pwrite/paddr/pwdata/pstrb in,
//            prdata/pready/pslverr out)
// Build option: APB_SLV_WAIT_EN -- when defined, WAIT_STATES pready-low cycles
// are inserted in every ACCESS phase; when undefined every transfer is 2 cycles.
module apb_slave_mem
    import apb_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic            pclk,
    input  logic            preset,
    apb_slave_mem_if.slave  bus
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = strb_lsb(DATA_WIDTH);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    if (WAIT_STATES > 15) begin : g_bad_wait
        $error("apb_slave_mem: WAIT_STATES must be in 0..15");
    end
    if ((1 << IDX_W) != MEM_DEPTH) begin : g_bad_depth
        $error("apb_slave_mem: MEM_DEPTH must be a power of two");
    end

    state_t                 r_state;
    logic                   r_err;
    logic                   r_write;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_W-1:0]      r_strb;

    logic                   w_setup;
    logic                   w_err;
    logic                   w_done;
    logic                   w_we;
    logic [IDX_W-1:0]       w_idx;
    logic [DATA_WIDTH-1:0]  w_rdata;

    // Any address bit above the index range set means word index >= MEM_DEPTH.
    assign w_idx   = IDX_W'(bus.paddr >> LSB);
    assign w_err   = (|(bus.paddr & ALIGN_MASK))
                   || (|(bus.paddr >> (LSB + IDX_W)))
                   || (!bus.pwrite && (|bus.pstrb));
    assign w_setup = (r_state == IDLE) && bus.psel && !bus.penable;

`ifdef APB_SLV_WAIT_EN
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES);
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    assign w_done = (r_wait_cnt == WAIT_LAST);
`else
    assign w_done = 1'b1;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
`ifdef APB_SLV_WAIT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // penable high while idle is a protocol violation and is ignored.
                    if (w_setup) begin
                        r_err   <= w_err;
                        r_write <= bus.pwrite;
                        r_idx   <= w_idx;
                        r_wdata <= bus.pwdata;
                        r_strb  <= bus.pstrb;
`ifdef APB_SLV_WAIT_EN
                        r_wait_cnt <= '0;
`endif
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!bus.psel) begin
                        r_state <= IDLE;
                    end else if (bus.penable) begin
                        if (w_done) begin
                            r_state <= IDLE;
                        end
`ifdef APB_SLV_WAIT_EN
                        else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory commits only on the completion edge of an error-free write, so an
    // abort or reset before completion leaves the word untouched.
    assign w_we = (r_state == ACCESS) && bus.psel && bus.penable && w_done
                  && r_write && !r_err;

    apb_slv_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_ram (
        .i_clk   (pclk),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_strb),
        .i_re    (w_setup && !bus.pwrite),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    assign bus.pready  = (r_state == ACCESS) && w_done;
    assign bus.pslverr = (r_state == ACCESS) && r_err;
    assign bus.prdata  = ((r_state == ACCESS) && !r_err && !r_write) ? w_rdata : '0;

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB4 completer with a word-organised local memory, sitting directly downstream of the APB master interface. It consumes the master's psel/penable/paddr/pwrite/pwdata/pstrb and returns prdata/pready/pslverr, acting as the addressable target the master's transfers terminate on. It provides programmable wait-state insertion, byte-strobed writes, and error responses for illegal accesses.

## Interface
- ADDR_WIDTH, 8: byte address width of paddr.
- DATA_WIDTH, 32: data bus width; legal values 8, 16, 32, 64.
- MEM_DEPTH, 32: number of DATA_WIDTH words; power of two, ≤ 2^(ADDR_WIDTH − log2(DATA_WIDTH/8)).
- WAIT_STATES, 2: pready-low cycles inserted in every ACCESS phase; range 0–15.

Ports:
- pclk  in  1  bus clock; all state on rising edge.
- preset  in  1  asynchronous, active-high reset.
- psel  in  1  completer select.
- penable  in  1  second and subsequent transfer cycles.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte lanes.
- prdata  out  DATA_WIDTH  read data; valid when pready=1 and pwrite=0.
- pready  out  1  transfer completes on the edge where this is 1.
- pslverr  out  1  error response; meaningful only when pready=1.

## Operation
- Let LSB = log2(DATA_WIDTH/8). Word index = paddr[LSB+log2(MEM_DEPTH)−1 : LSB].
- FSM states: IDLE and ACCESS.
  - IDLE, psel=1, penable=0 (SETUP) → capture paddr, pwrite, pwdata, pstrb; evaluate error; clear wait_cnt; go to ACCESS.
  - IDLE with penable=1 is a protocol violation. Ignore it: stay in IDLE with pready=0.
  - ACCESS, psel=1, penable=1, wait_cnt < WAIT_STATES → wait_cnt++.
  - ACCESS, psel=1, penable=1, wait_cnt = WAIT_STATES → completion edge:
    - if the captured write is error-free, commit it with strobes;
    - go to IDLE.
  - ACCESS with psel=0 aborts the transfer. Go to IDLE; no memory write.
- Error (pslverr=1) is set if any of these holds:
  - paddr[LSB−1:0] ≠ 0 (misaligned);
  - word index ≥ MEM_DEPTH, i.e. any paddr bit above the index range is set;
  - read with pstrb ≠ 0.
- An errored transfer never modifies memory, and its prdata is 0.
- Reads sample memory at the SETUP edge into a prdata register.
- Writes update only the lanes whose pstrb bit is 1. pstrb=0 on a write is legal and changes nothing.
- Memory contents are not reset. Reads of never-written words return X in simulation.

## Timing
- Reset values: prdata=0, pready=0, pslverr=0, state=IDLE, wait_cnt=0.
- Asserting preset mid-transfer discards the transfer; no partial write.
- pready = (state==ACCESS) && (wait_cnt==WAIT_STATES), decoded from registers with no input combinational path.
- pslverr and prdata are held stable for the whole ACCESS phase and are 0 outside it.
- Transfer length = 2 + WAIT_STATES cycles.
- Back-to-back transfers: a SETUP in the cycle after completion is accepted with no idle cycle.
- A write followed by a read of the same word returns the new data. The write commits at completion, before the next SETUP sample.
- Input changes during ACCESS have no effect; captured values are used.

## Configuration
- APB_SLV_WAIT_EN defined:
  - WAIT_STATES is honoured and wait_cnt is implemented.
- APB_SLV_WAIT_EN undefined:
  - wait_cnt is removed and WAIT_STATES is ignored.
  - pready is 1 in the first ACCESS cycle, so every transfer takes 2 cycles.

## Structure
- Package apb_slv_pkg holds:
  - the state enum {IDLE, ACCESS};
  - the default-parameter constants;
  - the localparam helper for LSB (strobe width).
- Sub-module apb_slv_ram holds the byte-enable memory:
  - one write port with byte enables;
  - one registered read port.
- The FSM, error decode and wait counter stay in apb_slave_mem.

## Test plan
All scenarios use defaults: DATA_WIDTH 32, MEM_DEPTH 32, WAIT_STATES 2, with the macro defined.
- Reset, then idle: prdata=0, pready=0, pslverr=0 in every cycle.
- Write 0xDEADBEEF to 0x10 with pstrb=0xF, then read 0x10:
  - each transfer shows pready low for 2 ACCESS cycles, then high;
  - the read returns 0xDEADBEEF with pslverr=0.
- Write 0x11223344 to 0x10 with pstrb=0b0101, then read 0x10: returns 0xDE22BE44.
- Read at 0x80 (out of range) → pslverr=1, prdata=0. Write 0xFFFFFFFF to 0x12 (misaligned) → pslverr=1, and a later read of 0x10 still returns 0xDE22BE44.
- Abort: write to 0x20; in the second ACCESS cycle, drop psel. A subsequent read of 0x20 returns the prior value. Assert preset mid-write and expect the same outcome, with outputs 0 immediately.
- Back-to-back: write 0x20, then SETUP a read of 0x20 in the next cycle. Expect 4-cycle transfers with no gap, returning the written data. Repeat with the macro undefined and expect pready in the first ACCESS cycle.
